// File: rtl/reservation_station_pkg.sv
// -----------------------------------------------------------------------------
// reservation_station_pkg
// Shared types and helpers for the reservation station.
//   operand_t   : {valid, value} as delivered by the register-file read stage.
//                 Inside a slot, 'valid' is the operand's ready bit. When it is
//                 0, value[RS_TAG_W-1:0] holds the pending physical tag.
//   rs_entry_t  : one queue slot (op, dest_tag, two operands).
//   tag_hit     : true when a broadcast resolves a pending operand.
//   wake_operand: returns the operand after applying a broadcast.
// The top module's TAG_W/OP_W parameters default to RS_TAG_W/RS_OP_W. The slot
// struct is built from these package widths, so the two must stay equal.
// -----------------------------------------------------------------------------
package reservation_station_pkg;

    localparam int RS_TAG_W  = 16;
    localparam int RS_OP_W   = 8;
    localparam int RS_DATA_W = 32;

    typedef struct packed {
        logic                 valid;
        logic [RS_DATA_W-1:0] value;
    } operand_t;

    typedef struct packed {
        logic [RS_OP_W-1:0]  op;
        logic [RS_TAG_W-1:0] dest_tag;
        operand_t            src1;
        operand_t            src2;
    } rs_entry_t;

    function automatic logic tag_hit(input operand_t o, input logic en,
                                     input logic [RS_TAG_W-1:0] tag);
        return en && !o.valid && (o.value[RS_TAG_W-1:0] == tag);
    endfunction

    function automatic operand_t wake_operand(input operand_t o, input logic en,
                                              input logic [RS_TAG_W-1:0] tag,
                                              input logic [RS_DATA_W-1:0] data);
        operand_t r;
        r.valid = 1'b1;
        r.value = data;
        return tag_hit(o, en, tag) ? r : o;
    endfunction

endpackage

// File: rtl/reservation_station_oldest_ready_select.sv
// -----------------------------------------------------------------------------
// rs_oldest_ready_select
// Priority encoder: returns the lowest set index of 'ready' (the oldest ready
// slot) and whether any bit is set.
//   ready : in  N     per-slot ready vector, bit 0 = oldest
//   index : out IW    lowest set bit position (0 when none set)
//   found : out 1     at least one bit set
// -----------------------------------------------------------------------------
module rs_oldest_ready_select #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  ready,
    output logic [IW-1:0] index,
    output logic          found
);

    // Scan from the youngest down so the oldest set bit is the last one written.
    always_comb begin
        index = '0;
        found = |ready;
        for (int i = N - 1; i >= 0; i--) begin
            index = ready[i] ? IW'(i) : index;
        end
    end

endmodule

// File: rtl/reservation_station.sv
// -----------------------------------------------------------------------------
// reservation_station
// Operand-wait buffer between register-file read and the ALU. Holds up to DEPTH
// instructions in a collapsing queue (slot 0 oldest), resolves pending operand
// tags from the completion broadcast and issues the oldest fully-ready entry.
//
// Ports:
//   clock, reset (async, active-high), flash (sync discard of all entries)
//   dispatch_*  : incoming instruction, dispatch_ready = (count < DEPTH)
//   cdb_*       : completion broadcast (tag, data)
//   issue_*     : valid/ready issue handshake; data outputs are 0 when idle
//   count       : current occupancy
//
// Build option: RS_CDB_BYPASS_EN -- when defined, a slot whose only missing
// operands match the current broadcast is issuable this cycle, with the
// operand taken straight from cdb_data. Undefined: wakeup is visible from the
// next cycle only.
// -----------------------------------------------------------------------------
module reservation_station
    import reservation_station_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = RS_TAG_W,
    parameter int OP_W  = RS_OP_W
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flash,
    input  logic                       dispatch_en,
    output logic                       dispatch_ready,
    input  logic [OP_W-1:0]            dispatch_op,
    input  logic                       dispatch_src1_valid,
    input  logic [31:0]                dispatch_src1_value,
    input  logic                       dispatch_src2_valid,
    input  logic [31:0]                dispatch_src2_value,
    input  logic [TAG_W-1:0]           dispatch_dest_tag,
    input  logic                       cdb_en,
    input  logic [TAG_W-1:0]           cdb_tag,
    input  logic [31:0]                cdb_data,
    output logic                       issue_valid,
    input  logic                       issue_ready,
    output logic [OP_W-1:0]            issue_op,
    output logic [31:0]                issue_src1,
    output logic [31:0]                issue_src2,
    output logic [TAG_W-1:0]           issue_dest_tag,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    rs_entry_t       slots_r [DEPTH];
    logic [CW-1:0]   count_r;
    // A presented-but-refused entry is pinned so a later wakeup of an older
    // slot cannot change the issue outputs mid-handshake.
    logic            hold_r;
    logic [IW-1:0]   hold_idx_r;

    logic [DEPTH-1:0] ready_vec_s;
    logic [IW-1:0]    found_idx_s;
    logic             found_s;
    logic [IW-1:0]    sel_idx_s;
    rs_entry_t        sel_s;
    logic             fire_s;
    logic             disp_fire_s;
    logic [CW-1:0]    count_after_s;
    rs_entry_t        new_entry_s;
    rs_entry_t        shifted_s [DEPTH];
    rs_entry_t        placed_s  [DEPTH];
    rs_entry_t        woken_s   [DEPTH];

    assign count          = count_r;
    assign dispatch_ready = (count_r < CW'(DEPTH));

    // Per-slot readiness, optionally counting operands resolved by this broadcast.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
`ifdef RS_CDB_BYPASS_EN
            ready_vec_s[i] = (CW'(i) < count_r)
                && (slots_r[i].src1.valid || tag_hit(slots_r[i].src1, cdb_en, cdb_tag))
                && (slots_r[i].src2.valid || tag_hit(slots_r[i].src2, cdb_en, cdb_tag));
`else
            ready_vec_s[i] = (CW'(i) < count_r) && slots_r[i].src1.valid
                && slots_r[i].src2.valid;
`endif
        end
    end

    rs_oldest_ready_select #(.N(DEPTH), .IW(IW)) u_select (
        .ready (ready_vec_s),
        .index (found_idx_s),
        .found (found_s)
    );

    assign sel_idx_s   = hold_r ? hold_idx_r : found_idx_s;
    assign sel_s       = slots_r[sel_idx_s];
    assign issue_valid = hold_r | found_s;

    // Issue data mux; zero while nothing is issuable.
    always_comb begin
        issue_op       = '0;
        issue_src1     = 32'd0;
        issue_src2     = 32'd0;
        issue_dest_tag = '0;
        if (issue_valid) begin
            issue_op       = sel_s.op;
            issue_dest_tag = sel_s.dest_tag;
`ifdef RS_CDB_BYPASS_EN
            issue_src1     = sel_s.src1.valid ? sel_s.src1.value : cdb_data;
            issue_src2     = sel_s.src2.valid ? sel_s.src2.value : cdb_data;
`else
            issue_src1     = sel_s.src1.value;
            issue_src2     = sel_s.src2.value;
`endif
        end else begin
            issue_op       = '0;
        end
    end

    assign fire_s        = issue_valid && issue_ready;
    assign disp_fire_s   = dispatch_en && dispatch_ready;
    assign count_after_s = count_r - CW'(fire_s);

    assign new_entry_s.op          = dispatch_op;
    assign new_entry_s.dest_tag    = dispatch_dest_tag;
    assign new_entry_s.src1.valid  = dispatch_src1_valid;
    assign new_entry_s.src1.value  = dispatch_src1_value;
    assign new_entry_s.src2.valid  = dispatch_src2_valid;
    assign new_entry_s.src2.value  = dispatch_src2_value;

    // Next queue contents: collapse over the issued slot, append, then wake up.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            shifted_s[i] = slots_r[i];
        end
        for (int i = 0; i < DEPTH - 1; i++) begin
            shifted_s[i] = (fire_s && (IW'(i) >= sel_idx_s)) ? slots_r[i+1] : slots_r[i];
        end
        for (int i = 0; i < DEPTH; i++) begin
            placed_s[i] = (disp_fire_s && (CW'(i) == count_after_s)) ? new_entry_s
                                                                      : shifted_s[i];
            woken_s[i]      = placed_s[i];
            woken_s[i].src1 = wake_operand(placed_s[i].src1, cdb_en, cdb_tag, cdb_data);
            woken_s[i].src2 = wake_operand(placed_s[i].src2, cdb_en, cdb_tag, cdb_data);
        end
    end

    // State registers; flash drops everything and cancels same-cycle updates.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                slots_r[i] <= '0;
            end
            count_r    <= '0;
            hold_r     <= 1'b0;
            hold_idx_r <= '0;
        end else if (flash) begin
            count_r    <= '0;
            hold_r     <= 1'b0;
            hold_idx_r <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                slots_r[i] <= woken_s[i];
            end
            count_r    <= count_after_s + CW'(disp_fire_s);
            hold_r     <= issue_valid && !issue_ready;
            hold_idx_r <= sel_idx_s;
        end
    end

endmodule
